// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
//   Shared definitions for the multiplexed seven-segment scan controller:
//   active-low glyph constants ({g,f,e,d,c,b,a}, 0 = segment lit), the
//   all-off pattern and the scan FSM state encoding.
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl_if
//   Groups the scan controller's control/data inputs and display outputs.
//   master : drives Enable, LzbEn, BcdIn; observes the display outputs.
//   slave  : the scan controller itself.
//   Signals:
//     Enable    1 = scan, 0 = display dark
//     LzbEn     1 = leading-zero blanking on
//     BcdIn     4*NUM_DIGITS packed digits, digit 0 in the low nibble
//     Segment   active-low {g,f,e,d,c,b,a}
//     DigitSel  one-hot active-high digit enable
//     FrameTick 1-cycle pulse at the start of each frame
// -----------------------------------------------------------------------------
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    Enable;
    logic                    LzbEn;
    logic [4*NUM_DIGITS-1:0] BcdIn;
    logic [6:0]              Segment;
    logic [NUM_DIGITS-1:0]   DigitSel;
    logic                    FrameTick;

    modport master (
        output Enable,
        output LzbEn,
        output BcdIn,
        input  Segment,
        input  DigitSel,
        input  FrameTick
    );

    modport slave (
        input  Enable,
        input  LzbEn,
        input  BcdIn,
        output Segment,
        output DigitSel,
        output FrameTick
    );
endinterface

// File: rtl/hex_to_sevseg.sv
// -----------------------------------------------------------------------------
// hex_to_sevseg
//   Pure combinational hex digit to active-low seven-segment decoder.
//   Values 10..15 show A, b, C, d, E, F.
//   Ports:
//     hex_i  4-bit digit value
//     seg_o  active-low {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex_to_sevseg
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Glyph lookup.
    always_comb begin
        seg_o = SEG_OFF;
        case (hex_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            4'hA:    seg_o = SEG_A;
            4'hB:    seg_o = SEG_B;
            4'hC:    seg_o = SEG_C;
            4'hD:    seg_o = SEG_D;
            4'hE:    seg_o = SEG_E;
            4'hF:    seg_o = SEG_F;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexes one hex-to-seven-segment decoder across NUM_DIGITS
//   digits. Each digit is lit for PRESCALE cycles, followed by BLANK_CYCLES
//   all-off guard cycles. The BCD input is snapshotted once per frame so a
//   counter carry mid-frame never tears the display. Optional leading-zero
//   blanking hides high-order zero digits (digit 0 always shown).
//   Ports:
//     Clock  system clock, rising edge
//     Reset  asynchronous, active-low
//     bus    seg_scan_ctrl_if slave modport (Enable, LzbEn, BcdIn in;
//            Segment, DigitSel, FrameTick out, all registered)
// -----------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic           Clock,
    input  logic           Reset,
    seg_scan_ctrl_if.slave bus
);

    // One counter times both the lit and the dark phase, so size it for the longer.
    localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int IW      = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] PRE_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    scan_state_e             state_q, state_d;
    logic [CW-1:0]           cnt_q,   cnt_d;
    logic [IW-1:0]           idx_q,   idx_d;
    logic [4*NUM_DIGITS-1:0] snap_q,  snap_d;
    logic [6:0]              seg_q,   seg_d;
    logic [NUM_DIGITS-1:0]   sel_q,   sel_d;
    logic                    tick_q,  tick_d;

    logic [3:0]              digit_s;
    logic [6:0]              glyph_s;
    logic [NUM_DIGITS-1:0]   blank_s;
    logic                    blank_cur_s;

    // State, counters, snapshot and output registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            seg_q   <= SEG_OFF;
            sel_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
        end
    end

    // Scan FSM next state; the snapshot is taken only when a frame (re)starts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        if (!bus.Enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    idx_d   = '0;
                    snap_d  = bus.BcdIn;
                end
                SHOW: begin
                    if (cnt_q == PRE_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                BLANK: begin
                    if (cnt_q == BLK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d  = '0;
                            snap_d = bus.BcdIn;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Leading-zero mask: a digit is blanked when it and every higher digit are zero.
    always_comb begin
        logic zero_run_v;
        zero_run_v = 1'b1;
        blank_s    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run_v = zero_run_v & (snap_q[4*i +: 4] == 4'd0);
            blank_s[i] = bus.LzbEn & zero_run_v & (i != 0);
        end
    end

    // Select the current digit from the frame snapshot for the shared decoder.
    always_comb begin
        digit_s     = snap_q[{idx_q, 2'b00} +: 4];
        blank_cur_s = blank_s[idx_q];
    end

    hex_to_sevseg u_dec (
        .hex_i (digit_s),
        .seg_o (glyph_s)
    );

    // Output next values; dropping Enable darkens the display on the very next edge.
    always_comb begin
        seg_d  = SEG_OFF;
        sel_d  = '0;
        tick_d = 1'b0;
        if (bus.Enable && (state_q == SHOW)) begin
            sel_d  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
            seg_d  = blank_cur_s ? SEG_OFF : glyph_s;
            tick_d = (idx_q == '0) && (cnt_q == '0);
        end else begin
            seg_d  = SEG_OFF;
            sel_d  = '0;
            tick_d = 1'b0;
        end
    end

    assign bus.Segment   = seg_q;
    assign bus.DigitSel  = sel_q;
    assign bus.FrameTick = tick_q;

endmodule
